acc_scheduler: RTL

//  Shares one 8-bit accumulator (acc_out <= acc_out + acc_in every clk) among N requesters.

---
 rtl/acc_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/acc_scheduler.sv
// acc_scheduler: round-robin arbiter that lends one free-running accumulator
// to N requesters, streams the winner's burst into it and returns the burst
// sum as the difference between the accumulator value after and before.
module acc_scheduler #(
   parameter int N  = 4,
   parameter int W  = 8,
   parameter int LW = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req,
   input  logic [N*LW-1:0]   req_len,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      acc_in,
   input  logic [W-1:0]      acc_out,
   output logic [W-1:0]      res_data,
   output logic [N-1:0]      res_valid,
   output logic              busy
);

   localparam int GW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [GW-1:0]   r_gnt;
   logic [GW-1:0]   r_last;
   logic [LW-1:0]   r_cnt;
   logic [LW-1:0]   r_len;
   logic [W-1:0]    r_base;
   logic [W-1:0]    r_res_data;
   logic [N-1:0]    r_res_valid;

   logic [LW-1:0]   w_len_arr  [N];
   logic [W-1:0]    w_data_arr [N];
   logic [GW-1:0]   w_cand     [N];
   logic [N-1:0]    w_hit;
   logic [N-1:0]    w_onehot;
   logic [GW-1:0]   w_pick;
   logic            w_any;
   logic            w_accept;
   logic [LW-1:0]   w_len_sel;

   // Unpack the flat per-requester buses and build the round-robin search order:
   // candidate gi is the requester gi+1 positions after the last one served.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_req
         assign w_len_arr[gi]  = req_len[gi*LW +: LW];
         assign w_data_arr[gi] = in_data[gi*W +: W];
         assign w_cand[gi]     = GW'((int'(r_last) + gi + 1) % N);
         assign w_hit[gi]      = req[w_cand[gi]];
         assign w_onehot[gi]   = (r_gnt == GW'(gi));
      end
   endgenerate

   // Pick the nearest pending requester after the last owner; scanning from the
   // far end lets the closest hit overwrite the others.
   always_comb begin
      w_any  = 1'b0;
      w_pick = r_last;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            w_any  = 1'b1;
            w_pick = w_cand[k];
         end
      end
   end

   assign w_len_sel = w_len_arr[w_pick];

   // Next-state and streaming outputs; only the granted requester is ever ready.
   always_comb begin
      w_state_next = r_state;
      in_ready     = '0;
      acc_in       = '0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any) begin
               w_state_next = (w_len_sel == '0) ? S_DRAIN : S_RUN;
            end
         end
         S_RUN: begin
            in_ready = w_onehot;
            if (in_valid[r_gnt]) begin
               w_accept = 1'b1;
               acc_in   = w_data_arr[r_gnt];
               if (r_cnt == r_len - LW'(1)) begin
                  w_state_next = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Grant capture, operand counting and result generation; the base snapshot
   // taken at grant time makes the accumulator's history irrelevant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gnt       <= '0;
         r_last      <= GW'(N - 1);
         r_cnt       <= '0;
         r_len       <= '0;
         r_base      <= '0;
         r_res_data  <= '0;
         r_res_valid <= '0;
      end else begin
         r_res_valid <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt  <= w_pick;
                  r_len  <= w_len_sel;
                  r_base <= acc_out;
                  r_cnt  <= '0;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + LW'(1);
               end
            end
            S_DRAIN: begin
               r_res_data  <= acc_out - r_base;
               r_res_valid <= w_onehot;
               r_last      <= r_gnt;
            end
            default: begin
            end
         endcase
      end
   end

   assign res_data  = r_res_data;
   assign res_valid = r_res_valid;
   assign busy      = (r_state != S_IDLE);

endmodule
